idexe_pipe_reg_hz: RTL and testbench

- Parametrised ID/EXE pipeline register, the successor to the fixed 32-bit ID/EXE stage register.
- Adds the following behaviour:
  - a valid bit;
  - downstream stall (hold);
  - flush (squash into a bubble);
  - built-in load-use hazard detection with automatic bubble insertion;
  - a saturating bubble counter for performance debug.
- Sits between the decode stage and the ALU/execute stage. The decode/fetch stages consume `load_use_stall` to freeze the PC and the IF/ID register.

---
 rtl/idexe_pipe_reg_hz.sv | 188 ++++++++++++++++++
 tb/tb_idexe_pipe_reg_hz.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/idexe_pipe_reg_hz.sv
`default_nettype none
// ============================================================================
//  Module   : idexe_pipe_reg_hz
//  Purpose  : Parametrised ID/EXE pipeline register. It has a valid bit,
//             downstream hold, flush-to-bubble, load-use hazard detection
//             with automatic bubble insertion, and a saturating bubble
//             counter for performance debug.
//  Revision : 1.0  initial release
// ============================================================================
module idexe_pipe_reg_hz #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              aluimm,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [REG_AW-1:0] destReg,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [DATA_W-1:0] imm32,
  output logic              e_valid,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic [ALUC_W-1:0] ealuc,
  output logic [REG_AW-1:0] edestReg,
  output logic [DATA_W-1:0] eqa,
  output logic [DATA_W-1:0] eqb,
  output logic [DATA_W-1:0] eimm32,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // EXE stage state
  // --------------------------------------------------------------------------
  logic              e_valid_q,  e_valid_d;
  logic              ewreg_q,    ewreg_d;
  logic              em2reg_q,   em2reg_d;
  logic              ewmem_q,    ewmem_d;
  logic              ealuimm_q,  ealuimm_d;
  logic [ALUC_W-1:0] ealuc_q,    ealuc_d;
  logic [REG_AW-1:0] edest_q,    edest_d;
  logic [DATA_W-1:0] eqa_q,      eqa_d;
  logic [DATA_W-1:0] eqb_q,      eqb_d;
  logic [DATA_W-1:0] eimm_q,     eimm_d;
  logic [CNT_W-1:0]  bcount_q,   bcount_d;

  // --------------------------------------------------------------------------
  // Hazard / bubble decode
  // --------------------------------------------------------------------------
  logic w_exe_is_load;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;
  logic w_counted_bubble;
  logic w_bubble;

  // A load in EXE whose destination is a real register (r0 never hazards).
  assign w_exe_is_load = e_valid_q & ewreg_q & em2reg_q & (edest_q != '0);
  assign w_rs_hit      = use_rs & (rs == edest_q);
  assign w_rt_hit      = use_rt & (rt == edest_q);

  // Evaluated from current EXE contents even while stalled, so ID keeps
  // holding for as long as the load sits in EXE.
  assign w_load_use       = w_exe_is_load & id_valid & (w_rs_hit | w_rt_hit);
  assign w_counted_bubble = flush | w_load_use;
  assign w_bubble         = w_counted_bubble | ~id_valid;

  // Next-state select: hold on stall, zero on bubble, otherwise capture ID.
  always_comb begin
    e_valid_d = e_valid_q;
    ewreg_d   = ewreg_q;
    em2reg_d  = em2reg_q;
    ewmem_d   = ewmem_q;
    ealuimm_d = ealuimm_q;
    ealuc_d   = ealuc_q;
    edest_d   = edest_q;
    eqa_d     = eqa_q;
    eqb_d     = eqb_q;
    eimm_d    = eimm_q;
    if (!stall) begin
      if (w_bubble) begin
        // Zeroed controls guarantee a bubble never writes regfile or memory.
        e_valid_d = 1'b0;
        ewreg_d   = 1'b0;
        em2reg_d  = 1'b0;
        ewmem_d   = 1'b0;
        ealuimm_d = 1'b0;
        ealuc_d   = '0;
        edest_d   = '0;
        eqa_d     = '0;
        eqb_d     = '0;
        eimm_d    = '0;
      end else begin
        e_valid_d = 1'b1;
        ewreg_d   = wreg;
        em2reg_d  = m2reg;
        ewmem_d   = wmem;
        ealuimm_d = aluimm;
        ealuc_d   = aluc;
        edest_d   = destReg;
        eqa_d     = qa;
        eqb_d     = qb;
        eimm_d    = imm32;
      end
    end
  end

  // Bubble counter next value: only flush / load-use bubbles count, saturating.
  always_comb begin
    bcount_d = bcount_q;
    if (!stall && w_counted_bubble && (bcount_q != C_CNT_MAX)) begin
      bcount_d = bcount_q + C_CNT_ONE;
    end
  end

  // EXE register bank with asynchronous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_valid_q <= 1'b0;
      ewreg_q   <= 1'b0;
      em2reg_q  <= 1'b0;
      ewmem_q   <= 1'b0;
      ealuimm_q <= 1'b0;
      ealuc_q   <= '0;
      edest_q   <= '0;
      eqa_q     <= '0;
      eqb_q     <= '0;
      eimm_q    <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      ewreg_q   <= ewreg_d;
      em2reg_q  <= em2reg_d;
      ewmem_q   <= ewmem_d;
      ealuimm_q <= ealuimm_d;
      ealuc_q   <= ealuc_d;
      edest_q   <= edest_d;
      eqa_q     <= eqa_d;
      eqb_q     <= eqb_d;
      eimm_q    <= eimm_d;
    end
  end

  // Performance counter register with asynchronous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bcount_q <= '0;
    end else begin
      bcount_q <= bcount_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign e_valid        = e_valid_q;
  assign ewreg          = ewreg_q;
  assign em2reg         = em2reg_q;
  assign ewmem          = ewmem_q;
  assign ealuimm        = ealuimm_q;
  assign ealuc          = ealuc_q;
  assign edestReg       = edest_q;
  assign eqa            = eqa_q;
  assign eqb            = eqb_q;
  assign eimm32         = eimm_q;
  assign load_use_stall = w_load_use;
  assign bubble_count   = bcount_q;

endmodule
`default_nettype wire

// File: tb/tb_idexe_pipe_reg_hz.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idexe_pipe_reg_hz
//  Purpose  : Directed self-checking bench for idexe_pipe_reg_hz. A second
//             instance with a 2-bit counter exercises saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_idexe_pipe_reg_hz;

  logic        clock = 1'b0;
  logic        resetn;
  logic        stall, flush, id_valid;
  logic        wreg, m2reg, wmem, aluimm;
  logic [3:0]  aluc;
  logic [4:0]  destReg, rs, rt;
  logic        use_rs, use_rt;
  logic [31:0] qa, qb, imm32;

  logic        e_valid, ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [4:0]  edestReg;
  logic [31:0] eqa, eqb, eimm32;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  logic        s_e_valid, s_ewreg, s_em2reg, s_ewmem, s_ealuimm;
  logic [3:0]  s_ealuc;
  logic [4:0]  s_edestReg;
  logic [31:0] s_eqa, s_eqb, s_eimm32;
  logic        s_load_use_stall;
  logic [1:0]  s_bubble_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  idexe_pipe_reg_hz u_dut (
    .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .wreg(wreg), .m2reg(m2reg), .wmem(wmem),
    .aluimm(aluimm), .aluc(aluc), .destReg(destReg), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .qa(qa), .qb(qb), .imm32(imm32),
    .e_valid(e_valid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuimm(ealuimm), .ealuc(ealuc), .edestReg(edestReg), .eqa(eqa),
    .eqb(eqb), .eimm32(eimm32), .load_use_stall(load_use_stall),
    .bubble_count(bubble_count)
  );

  idexe_pipe_reg_hz #(.CNT_W(2)) u_dut_sat (
    .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .wreg(wreg), .m2reg(m2reg), .wmem(wmem),
    .aluimm(aluimm), .aluc(aluc), .destReg(destReg), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .qa(qa), .qb(qb), .imm32(imm32),
    .e_valid(s_e_valid), .ewreg(s_ewreg), .em2reg(s_em2reg), .ewmem(s_ewmem),
    .ealuimm(s_ealuimm), .ealuc(s_ealuc), .edestReg(s_edestReg), .eqa(s_eqa),
    .eqb(s_eqb), .eimm32(s_eimm32), .load_use_stall(s_load_use_stall),
    .bubble_count(s_bubble_count)
  );

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    wreg = 1'b0; m2reg = 1'b0; wmem = 1'b0; aluimm = 1'b0; aluc = 4'h0;
    destReg = 5'd0; rs = 5'd0; rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    qa = 32'h0; qb = 32'h0; imm32 = 32'h0;

    // ---- reset state ----
    tick(); tick();
    check_eq("rst_e_valid", e_valid, 0);
    check_eq("rst_count",   bubble_count, 0);
    check_eq("rst_lus",     load_use_stall, 0);
    resetn = 1'b1;

    // ---- pass-through ----
    id_valid = 1; wreg = 1; aluimm = 1; aluc = 4'h3; destReg = 5'd9;
    rs = 5'd1; rt = 5'd2; use_rs = 1; use_rt = 1;
    qa = 32'h1234_5678; qb = 32'hCAFE_F00D; imm32 = 32'hFFFF_FFF0;
    tick();
    check_eq("pt_e_valid", e_valid, 1);
    check_eq("pt_eqa",     eqa, 32'h1234_5678);
    check_eq("pt_eqb",     eqb, 32'hCAFE_F00D);
    check_eq("pt_eimm",    eimm32, 32'hFFFF_FFF0);
    check_eq("pt_edest",   edestReg, 9);
    check_eq("pt_ealuc",   ealuc, 3);
    check_eq("pt_ewreg",   ewreg, 1);
    check_eq("pt_ealuimm", ealuimm, 1);
    check_eq("pt_em2reg",  em2reg, 0);
    check_eq("pt_count",   bubble_count, 0);

    // ---- load-use on rs ----
    m2reg = 1; destReg = 5'd8; use_rs = 0; use_rt = 0;
    tick();
    check_eq("ld_em2reg", em2reg, 1);
    check_eq("ld_edest",  edestReg, 8);
    m2reg = 0; destReg = 5'd3; rs = 5'd8; use_rs = 1; qa = 32'h11;
    #1;
    check_eq("lu_rs_stall", load_use_stall, 1);
    tick();
    check_eq("lu_bub_valid", e_valid, 0);
    check_eq("lu_bub_ewreg", ewreg, 0);
    check_eq("lu_bub_eqa",   eqa, 0);
    check_eq("lu_count",     bubble_count, 1);
    check_eq("lu_drop",      load_use_stall, 0);
    tick();
    check_eq("lu_resume_valid", e_valid, 1);
    check_eq("lu_resume_dest",  edestReg, 3);
    check_eq("lu_resume_count", bubble_count, 1);

    // ---- load-use on rt, and non-hazard variants ----
    m2reg = 1; destReg = 5'd8; use_rs = 0; use_rt = 0;
    tick();
    m2reg = 0; destReg = 5'd4; rt = 5'd8; use_rt = 1; rs = 5'd0;
    #1;
    check_eq("lu_rt_stall", load_use_stall, 1);
    rs = 5'd8; use_rs = 0; rt = 5'd2; use_rt = 1;
    #1;
    check_eq("no_use_rs", load_use_stall, 0);
    rt = 5'd8; id_valid = 0;
    #1;
    check_eq("no_id_valid", load_use_stall, 0);
    id_valid = 1; use_rt = 0;
    tick();
    check_eq("nohz_valid", e_valid, 1);
    check_eq("nohz_dest",  edestReg, 4);
    check_eq("nohz_count", bubble_count, 1);

    // ---- load to r0 never hazards ----
    m2reg = 1; destReg = 5'd0;
    tick();
    m2reg = 0; destReg = 5'd5; rs = 5'd0; use_rs = 1;
    #1;
    check_eq("r0_no_stall", load_use_stall, 0);
    tick();
    check_eq("r0_dest",  edestReg, 5);
    check_eq("r0_count", bubble_count, 1);

    // ---- stall beats flush ----
    use_rs = 0; qb = 32'hDEAD_BEEF; destReg = 5'd6;
    tick();
    check_eq("st_load_eqb", eqb, 32'hDEAD_BEEF);
    stall = 1; flush = 1; qb = 32'h0; destReg = 5'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("st_hold_eqb",   eqb, 32'hDEAD_BEEF);
      check_eq("st_hold_valid", e_valid, 1);
      check_eq("st_hold_dest",  edestReg, 6);
      check_eq("st_hold_count", bubble_count, 1);
    end
    stall = 0;
    tick();
    check_eq("fl_valid", e_valid, 0);
    check_eq("fl_eqb",   eqb, 0);
    check_eq("fl_count", bubble_count, 2);
    flush = 0;

    // ---- idle (no valid ID instruction) ----
    id_valid = 0; qa = 32'hA5A5_A5A5; wreg = 1; wmem = 1;
    tick();
    check_eq("idle_valid", e_valid, 0);
    check_eq("idle_eqa",   eqa, 0);
    check_eq("idle_ewreg", ewreg, 0);
    check_eq("idle_ewmem", ewmem, 0);
    tick();
    check_eq("idle_count", bubble_count, 2);

    // ---- asynchronous reset mid-cycle ----
    id_valid = 1;
    tick();
    check_eq("pre_rst_eqa", eqa, 32'hA5A5_A5A5);
    #2 resetn = 0;
    #1;
    check_eq("arst_valid", e_valid, 0);
    check_eq("arst_eqa",   eqa, 0);
    check_eq("arst_ewreg", ewreg, 0);
    check_eq("arst_count", bubble_count, 0);
    tick();
    resetn = 1;

    // ---- counter saturation (2-bit instance) ----
    flush = 1;
    tick(); check_eq("sat_1", s_bubble_count, 1);
    tick(); check_eq("sat_2", s_bubble_count, 2);
    tick(); check_eq("sat_3", s_bubble_count, 3);
    tick(); check_eq("sat_4", s_bubble_count, 3);
    tick(); check_eq("sat_5", s_bubble_count, 3);
    check_eq("wide_count_5", bubble_count, 5);
    flush = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
